// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the shared-adder arbiter: FSM state encoding,
// default sizes and the requester-index width function.
package adder_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int DEF_SIZE = 4;
  localparam int DEF_NREQ = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of request/response ports of the shared-adder arbiter.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both 1; a source holds valid and payload stable until that edge.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int NREQ = DEF_NREQ
);
  localparam int IDW = idx_width(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_a;
  logic [NREQ*SIZE-1:0] req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [SIZE:0]        res_data;
  logic [IDW-1:0]       res_id;
  state_t               dbg_state;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, dbg_state
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, dbg_state
  );

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational grant selection: round-robin from ptr when ADDER_ARB_RR_EN is
// defined, otherwise fixed priority with index 0 highest.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] start;
  logic [IDW-1:0] idx;
  logic           found;

`ifdef ADDER_ARB_RR_EN
  assign start = ptr;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`endif

  // NREQ is a power of two, so the IDW-bit add wraps the search naturally.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + IDW'(k);
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    if (found && en) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// One SIZE-bit adder shared by NREQ requesters with a registered result port.
// Define ADDER_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int NREQ = DEF_NREQ
) (
  input logic            clk,
  input logic            reset,
  adder_arbiter_if.slave bus
);
  localparam int IDW = idx_width(NREQ);

  state_t          state_q, state_d;
  logic [SIZE:0]   res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_en;
  logic            accept;
  logic [SIZE-1:0] op_a, op_b;

  // A new operand pair may enter only when the result register is empty or drains now.
  assign grant_en = (state_q == ST_IDLE || bus.res_ready) && !reset;
  assign accept   = grant_en && |bus.req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .en       (grant_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

`ifdef ADDER_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  assign ptr_d = accept ? grant_id + IDW'(1) : ptr_q;
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (!accept && bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.res_valid = (state_q == ST_HOLD);
    bus.req_ready = grant;
    bus.dbg_state = state_q;
  end

  // Operands only reach the result register, never an output combinationally.
  assign op_a       = bus.req_a[int'(grant_id)*SIZE +: SIZE];
  assign op_b       = bus.req_b[int'(grant_id)*SIZE +: SIZE];
  assign res_data_d = accept ? ({1'b0, op_a} + {1'b0, op_b}) : res_data_q;
  assign res_id_d   = accept ? grant_id : res_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign bus.res_data = res_data_q;
  assign bus.res_id   = res_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a cycle-level reference model.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int SIZE = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = SIZE + 1;
  localparam int W    = DW + IDW;
`ifdef ADDER_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adder_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

  adder_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [SIZE-1:0] opa [NREQ];
  logic [SIZE-1:0] opb [NREQ];

  task automatic pack_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*SIZE +: SIZE] = opa[i];
      bus.req_b[i*SIZE +: SIZE] = opb[i];
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let comb logic settle.
  task automatic apply(input logic r, input logic [NREQ-1:0] v, input logic rr);
    @(negedge clk);
    reset         = r;
    bus.req_valid = v;
    bus.res_ready = rr;
    pack_ops();
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_id    = 0;
  int            m_ptr   = 0;
  logic [W-1:0]  exp_q[$];

  function automatic int pick(input logic [NREQ-1:0] v);
    int start;
    start = RR_EN ? m_ptr : 0;
    for (int k = 0; k < NREQ; k++)
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [NREQ-1:0] v, input logic rr, output int g);
    logic [NREQ-1:0] e_ready;
    logic [W-1:0]    got;
    g       = (!r && (!m_valid || rr)) ? pick(v) : -1;
    e_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("rnd_ready", bus.req_ready, e_ready);
    check("rnd_valid", bus.res_valid, m_valid);
    check("rnd_data", bus.res_data, m_data);
    check("rnd_id", bus.res_id, m_id);
    if (!r && m_valid && rr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty @%0t: result consumed with no expected entry", $time);
      end else begin
        got = exp_q.pop_front();
        check("sb_data", bus.res_data, got[DW-1:0]);
        check("sb_id", bus.res_id, got[W-1:DW]);
      end
    end
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = DW'(int'(opa[g]) + int'(opb[g]));
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
      exp_q.push_back({IDW'(g), m_data});
    end else if (rr) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic            rst;
    logic [NREQ-1:0] v;
    logic            rr;
    logic [NREQ-1:0] e_ready;
    logic            e_valid;
    logic [DW-1:0]   e_data;
    logic [IDW-1:0]  e_id;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [NREQ-1:0] pend;
    logic            r, rr;
    int              g, eg;

    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Operand sums: r0 3+4=07, r1 8+9=11, r2 F+1=10, r3 F+F=1E.
    opa[0] = 4'h3; opb[0] = 4'h4;
    opa[1] = 4'h8; opb[1] = 4'h9;
    opa[2] = 4'hF; opb[2] = 4'h1;
    opa[3] = 4'hF; opb[3] = 4'hF;

    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 5'h00, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 5'h00, 2'd0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 5'h00, 2'd0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 5'h07, 2'd0};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 5'h07, 2'd0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 5'h10, 2'd2};
    tbl[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 5'h10, 2'd2};
    tbl[7]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 5'h10, 2'd2};
    tbl[8]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 5'h10, 2'd2};
    tbl[9]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 5'h10, 2'd2};
    tbl[10] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 5'h11, 2'd1};
    tbl[11] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 5'h1E, 2'd3};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 5'h07, 2'd0};
    tbl[13] = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1, 5'h07, 2'd0};
    tbl[14] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 5'h00, 2'd0};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 5'h07, 2'd0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'h07, 2'd0};

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].rr);
      check($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_valid", i), bus.res_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_data", i), bus.res_data, tbl[i].e_data);
      check($sformatf("tbl%0d_id", i), bus.res_id, tbl[i].e_id);
      check($sformatf("tbl%0d_state", i), bus.dbg_state, tbl[i].e_valid);
    end

    // Fairness: all four requesting with res_ready high, one grant per cycle.
    apply(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 4'b1111, 1'b1);
      eg = RR_EN ? (i % NREQ) : 0;
      check($sformatf("fair%0d_ready", i), bus.req_ready, NREQ'(1) << eg);
      if (i > 0) begin
        check($sformatf("fair%0d_valid", i), bus.res_valid, 1'b1);
        check($sformatf("fair%0d_id", i), bus.res_id, RR_EN ? ((i - 1) % NREQ) : 0);
      end
    end

    // Wrap: grant 3, then 0 wins from 1001, then pointer sits at 1.
    apply(1'b1, 4'b0000, 1'b0);
    apply(1'b0, 4'b1000, 1'b1);
    check("wrap_g3", bus.req_ready, 4'b1000);
    apply(1'b0, 4'b1001, 1'b1);
    check("wrap_g0", bus.req_ready, 4'b0001);
    check("wrap_id3", bus.res_id, 2'd3);
    apply(1'b0, 4'b0011, 1'b1);
    check("wrap_ptr1", bus.req_ready, RR_EN ? 4'b0010 : 4'b0001);
    check("wrap_id0", bus.res_id, 2'd0);
    apply(1'b0, 4'b0000, 1'b1);
    check("wrap_last_id", bus.res_id, RR_EN ? 2'd1 : 2'd0);
    check("wrap_last_data", bus.res_data, RR_EN ? 5'h11 : 5'h07);

    // Randomized traffic: requesters hold operands until granted.
    apply(1'b1, 4'b0000, 1'b0);
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      r = (c == 0) || ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          opa[i]  = SIZE'($urandom);
          opb[i]  = SIZE'($urandom);
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      apply(r, pend, rr);
      model_step(r, pend, rr, g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one combinational SIZE-bit adder among NREQ requesters. Arbitrates per-requester valid/ready operand ports, computes `{carry, sum}` in one cycle, and returns the result with the winning requester's index through a registered valid/ready response port. Sits between the datapath clients (ALU front-ends, address generators) and the adder resource.

## Interface
- SIZE, 4, operand width; result is SIZE+1 bits.
- NREQ, 4, number of requesters; power of two, ≥2.
- IDW, $clog2(NREQ), requester index width (derived, not overridden).

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  bit i: requester i presents operands.
- req_ready  out  NREQ  one-hot or zero; bit i: requester i accepted this cycle.
- req_a  in  NREQ*SIZE  operand a of requester i in bits [i*SIZE +: SIZE].
- req_b  in  NREQ*SIZE  operand b, same packing.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  consumer accepts result.
- res_data  out  SIZE+1  {carry, sum} = a + b, zero-extended, no wrap.
- res_id  out  IDW  index of requester that produced res_data.

## Operation
- States: IDLE (result register empty), HOLD (result valid, awaiting res_ready).
- accept = (state==IDLE || res_ready) && |req_valid && !reset.
- When accept: winner g chosen by arbiter; req_ready[g]=1 combinationally, all other bits 0; at next edge res_data ← a[g]+b[g], res_id ← g, res_valid ← 1, state → HOLD.
- HOLD with res_ready=1 and no request: res_valid ← 0, state → IDLE; res_data/res_id keep last value.
- HOLD with res_ready=1 and request pending: consume and accept same cycle (back-to-back, no bubble).
- HOLD with res_ready=0: req_ready all 0; res_data, res_id, res_valid held stable.
- Arbitration: priority pointer ptr (IDW bits); search starts at ptr, increments mod NREQ; first valid wins. On each accept ptr ← (g+1) mod NREQ (wraps NREQ-1 → 0). ptr unchanged without accept.
- Requesters must hold req_valid and operands stable until req_ready; block does not check.

## Timing
- Reset values: state=IDLE, res_valid=0, res_data=0, res_id=0, ptr=0; req_ready=0 while reset high.
- Latency: operands accepted at edge k → res_valid=1 during cycle after edge k.
- Throughput: one result per cycle with res_ready held high.
- req_ready depends combinationally on req_valid, res_ready, state, ptr; no combinational path from operands to any output.
- Reset mid-HOLD: pending result discarded, res_valid=0 next cycle, ptr=0.

## Configuration
- ADDER_ARB_RR_EN defined: round-robin as in Operation (ptr rotates).
- ADDER_ARB_RR_EN undefined: fixed priority, index 0 highest; ptr logic removed, search always starts at 0. All other behaviour identical.

## Structure
- Package adder_arb_pkg: state encodings (ST_IDLE=1'b0, ST_HOLD=1'b1), index-width helper function.
- Sub-module rr_arbiter: combinational, inputs req[NREQ], ptr[IDW], en; outputs one-hot grant[NREQ] and grant_id[IDW]; contains the RR/fixed-priority selection under the macro. Pointer register and adder stay in adder_arbiter.

## Test plan
- Reset: assert reset 2 cycles with req_valid=4'b1111 → req_ready=0, res_valid=0, res_data=0, res_id=0; release → first grant to requester 0.
- Single request: req_valid=4'b0100, a2=4'hF, b2=4'h1, res_ready=1 → req_ready=4'b0100 that cycle; next cycle res_valid=1, res_data=5'h10, res_id=2.
- Fairness: req_valid=4'b1111 held, res_ready=1 → res_id sequence 0,1,2,3,0 on consecutive cycles; without ADDER_ARB_RR_EN → 0,0,0,0.
- Backpressure: result held, res_ready=0 for 3 cycles with requests pending → req_ready=0, res_data/res_id unchanged; raise res_ready → new result next cycle, no bubble.
- Wrap: grant requester 3, then req_valid=4'b1001 → requester 0 wins (RR), ptr=1.
- Reset mid-HOLD: res_valid=1, res_ready=0, pulse reset → res_valid=0 next cycle, subsequent grant starts at requester 0.
